// File: rtl/axi4_slave_pkg.sv
// Types shared by the AXI4 slave channel controllers: burst kinds, response codes
// and write-controller states.
package axi4_slave_pkg;

    typedef enum logic [1:0] {
        FIXED = 2'b00,
        INCR  = 2'b01,
        WRAP  = 2'b10,
        RSVD  = 2'b11
    } burst_t;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        DATA = 2'b01,
        RESP = 2'b10
    } wctrl_state_t;

endpackage

// File: rtl/axi4_burst_addr_next.sv
// Next beat byte address for FIXED/INCR/WRAP bursts; shared by the read and write
// controllers.
module axi4_burst_addr_next
    import axi4_slave_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 8
) (
    input  logic [ADDR_WIDTH-1:0] cur_addr,
    input  logic [2:0]            size,
    input  logic [LEN_WIDTH-1:0]  len,
    input  logic [1:0]            burst,
    output logic [ADDR_WIDTH-1:0] next_addr
);

    logic [ADDR_WIDTH-1:0] bytes;
    logic [ADDR_WIDTH-1:0] wrap_bytes;

    assign bytes      = ADDR_WIDTH'(1) << size;
    assign wrap_bytes = (ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size;

    always_comb begin
        next_addr = cur_addr;
        case (burst_t'(burst))
            // Aligning down first makes an unaligned start land on the next size boundary
            INCR:    next_addr = (cur_addr & ~(bytes - ADDR_WIDTH'(1))) + bytes;
            WRAP:    next_addr = (cur_addr & ~(wrap_bytes - ADDR_WIDTH'(1)))
                               | ((cur_addr + bytes) & (wrap_bytes - ADDR_WIDTH'(1)));
            default: next_addr = cur_addr;
        endcase
    end

endmodule

// File: rtl/axi4_slave_write_burst_ctrl.sv
// AXI4 slave write-burst sequencer: takes W beats after the AW stage latched a request,
// drives a single-port memory write port and returns the B response.
//
//  state | meaning
//  IDLE  | waiting for aw_start, ctrl_busy low
//  DATA  | accepting W beats, wready high
//  RESP  | bvalid high until bready
module axi4_slave_write_burst_ctrl
    import axi4_slave_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    aw_start,
    input  logic [ADDR_WIDTH-1:0]   aw_addr,
    input  logic [ID_WIDTH-1:0]     aw_id,
    input  logic [LEN_WIDTH-1:0]    aw_len,
    input  logic [2:0]              aw_size,
    input  logic [1:0]              aw_burst,
    output logic                    ctrl_busy,
    input  logic                    wvalid,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wlast,
    output logic                    wready,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_wstrb,
    output logic                    bvalid,
    output logic [ID_WIDTH-1:0]     bid,
    output logic [1:0]              bresp,
    input  logic                    bready
);

    localparam logic [2:0] MAX_SIZE = 3'($clog2(DATA_WIDTH / 8));

    wctrl_state_t          state_q, state_d;
    logic                  ctrl_busy_q, ctrl_busy_d;
    logic                  wready_q, wready_d;
    logic                  bvalid_q, bvalid_d;
    logic [ID_WIDTH-1:0]   bid_q, bid_d;
    logic [1:0]            bresp_q, bresp_d;
    logic                  err_q, err_d;
    logic [LEN_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;
    logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [2:0]            size_q, size_d;
    logic [1:0]            burst_q, burst_d;

    logic                  beat;
    logic                  final_beat;
    logic                  decode_err;
    logic                  wrap_len_ok;
    logic [ADDR_WIDTH-1:0] next_addr;

    axi4_burst_addr_next #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .LEN_WIDTH  (LEN_WIDTH)
    ) u_addr_next (
        .cur_addr  (cur_addr_q),
        .size      (size_q),
        .len       (len_q),
        .burst     (burst_q),
        .next_addr (next_addr)
    );

    assign wrap_len_ok = (aw_len == LEN_WIDTH'(1)) || (aw_len == LEN_WIDTH'(3))
                      || (aw_len == LEN_WIDTH'(7)) || (aw_len == LEN_WIDTH'(15));
    assign decode_err  = (burst_t'(aw_burst) == RSVD) || (aw_size > MAX_SIZE)
                      || ((burst_t'(aw_burst) == WRAP) && !wrap_len_ok);

    assign beat       = wvalid & wready_q;
    assign final_beat = (beat_cnt_q == len_q);

    always_comb begin
        state_d    = state_q;
        wready_d   = wready_q;
        bvalid_d   = bvalid_q;
        bid_d      = bid_q;
        bresp_d    = bresp_q;
        err_d      = err_q;
        beat_cnt_d = beat_cnt_q;
        cur_addr_d = cur_addr_q;
        len_d      = len_q;
        size_d     = size_q;
        burst_d    = burst_q;
        case (state_q)
            IDLE: begin
                if (aw_start) begin
                    state_d    = DATA;
                    wready_d   = 1'b1;
                    bid_d      = aw_id;
                    err_d      = decode_err;
                    beat_cnt_d = '0;
                    cur_addr_d = aw_addr;
                    len_d      = aw_len;
                    size_d     = aw_size;
                    burst_d    = aw_burst;
                end
            end
            DATA: begin
                if (beat) begin
                    beat_cnt_d = beat_cnt_q + LEN_WIDTH'(1);
                    cur_addr_d = next_addr;
                    if (final_beat) begin
                        state_d  = RESP;
                        wready_d = 1'b0;
                        bvalid_d = 1'b1;
                        err_d    = err_q | ~wlast;
                        bresp_d  = (err_q | ~wlast) ? SLVERR : OKAY;
                    end else if (wlast) begin
                        err_d = 1'b1;
                    end
                end
            end
            RESP: begin
                if (bready) begin
                    state_d  = IDLE;
                    bvalid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        ctrl_busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ctrl_busy_q <= 1'b0;
            wready_q    <= 1'b0;
            bvalid_q    <= 1'b0;
            bid_q       <= '0;
            bresp_q     <= '0;
            err_q       <= 1'b0;
            beat_cnt_q  <= '0;
            cur_addr_q  <= '0;
            len_q       <= '0;
            size_q      <= '0;
            burst_q     <= '0;
        end else begin
            state_q     <= state_d;
            ctrl_busy_q <= ctrl_busy_d;
            wready_q    <= wready_d;
            bvalid_q    <= bvalid_d;
            bid_q       <= bid_d;
            bresp_q     <= bresp_d;
            err_q       <= err_d;
            beat_cnt_q  <= beat_cnt_d;
            cur_addr_q  <= cur_addr_d;
            len_q       <= len_d;
            size_q      <= size_d;
            burst_q     <= burst_d;
        end
    end

    assign ctrl_busy = ctrl_busy_q;
    assign wready    = wready_q;
    assign bvalid    = bvalid_q;
    assign bid       = bid_q;
    assign bresp     = bresp_q;
    assign mem_we    = beat & ~err_q;
    assign mem_addr  = cur_addr_q;
    assign mem_wdata = wdata;
    assign mem_wstrb = wstrb;

endmodule

// File: tb/tb_axi4_slave_write_burst_ctrl.sv
// Directed bench for the write-burst controller: stimulus pushes expected memory writes
// and B responses into queues, a negedge monitor pops and compares them.
module tb_axi4_slave_write_burst_ctrl;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = 4;
    localparam int LW = 8;

    logic            clk;
    logic            rst;
    logic            aw_start;
    logic [AW-1:0]   aw_addr;
    logic [IW-1:0]   aw_id;
    logic [LW-1:0]   aw_len;
    logic [2:0]      aw_size;
    logic [1:0]      aw_burst;
    logic            ctrl_busy;
    logic            wvalid;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wstrb;
    logic            wlast;
    logic            wready;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [DW/8-1:0] mem_wstrb;
    logic            bvalid;
    logic [IW-1:0]   bid;
    logic [1:0]      bresp;
    logic            bready;

    axi4_slave_write_burst_ctrl #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .ID_WIDTH   (IW),
        .LEN_WIDTH  (LW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .aw_start  (aw_start),
        .aw_addr   (aw_addr),
        .aw_id     (aw_id),
        .aw_len    (aw_len),
        .aw_size   (aw_size),
        .aw_burst  (aw_burst),
        .ctrl_busy (ctrl_busy),
        .wvalid    (wvalid),
        .wdata     (wdata),
        .wstrb     (wstrb),
        .wlast     (wlast),
        .wready    (wready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .bvalid    (bvalid),
        .bid       (bid),
        .bresp     (bresp),
        .bready    (bready)
    );

    typedef struct {
        logic [AW-1:0]   a;
        logic [DW-1:0]   d;
        logic [DW/8-1:0] s;
    } wr_t;

    typedef struct {
        logic [IW-1:0] id;
        logic [1:0]    resp;
    } b_t;

    wr_t           wr_q[$];
    b_t            b_q[$];
    logic [AW-1:0] ea[$];
    int            checks = 0;
    int            fails  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares every presented write / response against the queues
    logic          hold_prev = 1'b0;
    logic [IW-1:0] bid_prev;
    logic [1:0]    bresp_prev;
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_we) begin
                if (wr_q.size() == 0) begin
                    chk("unexpected_mem_we", {32'd0, mem_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    wr_t e;
                    e = wr_q.pop_front();
                    chk("mem_addr", {32'd0, mem_addr}, {32'd0, e.a});
                    chk("mem_wdata", {32'd0, mem_wdata}, {32'd0, e.d});
                    chk("mem_wstrb", {60'd0, mem_wstrb}, {60'd0, e.s});
                end
            end
            if (bvalid && bready) begin
                if (b_q.size() == 0) begin
                    chk("unexpected_b", {62'd0, bresp}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    b_t e;
                    e = b_q.pop_front();
                    chk("bid", {60'd0, bid}, {60'd0, e.id});
                    chk("bresp", {62'd0, bresp}, {62'd0, e.resp});
                end
            end
            if (hold_prev) begin
                chk("bvalid_hold", {63'd0, bvalid}, 64'd1);
                chk("bid_hold", {60'd0, bid}, {60'd0, bid_prev});
                chk("bresp_hold", {62'd0, bresp}, {62'd0, bresp_prev});
            end
        end
        hold_prev  = bvalid && !bready && !rst;
        bid_prev   = bid;
        bresp_prev = bresp;
    end

    task automatic start_aw(input logic [AW-1:0] addr, input logic [IW-1:0] id,
                            input int len, input logic [2:0] size, input logic [1:0] burst);
        @(posedge clk);
        #1;
        aw_start = 1'b1;
        aw_addr  = addr;
        aw_id    = id;
        aw_len   = LW'(len);
        aw_size  = size;
        aw_burst = burst;
        @(posedge clk);
        #1;
        aw_start = 1'b0;
        chk("wready_after_aw", {63'd0, wready}, 64'd1);
        chk("busy_after_aw", {63'd0, ctrl_busy}, 64'd1);
    endtask

    // Called at posedge+1; returns at posedge+1 after the handshake edge
    task automatic send_beat(input logic [DW-1:0] d, input logic [DW/8-1:0] s, input logic last,
                             input bit exp_we, input logic [AW-1:0] exp_a);
        int n;
        if (exp_we) wr_q.push_back('{a: exp_a, d: d, s: s});
        wvalid = 1'b1;
        wdata  = d;
        wstrb  = s;
        wlast  = last;
        n = 0;
        while (!wready && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!wready) chk("wready_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        wvalid = 1'b0;
        wlast  = 1'b0;
    endtask

    task automatic run_burst(input logic [AW-1:0] addr, input logic [IW-1:0] id, input int len,
                             input logic [2:0] size, input logic [1:0] burst, input int wlast_idx,
                             input bit dec_err, input int gap, input int bdelay,
                             input logic [1:0] exp_resp);
        int n;
        start_aw(addr, id, len, size, burst);
        b_q.push_back('{id: id, resp: exp_resp});
        for (int i = 0; i <= len; i++) begin
            logic [DW-1:0]   d;
            logic [DW/8-1:0] s;
            d = 32'hD000_0000 | (32'(id) << 16) | 32'(i);
            s = 4'hF ^ 4'(i);
            send_beat(d, s, i == wlast_idx, !dec_err && (i <= wlast_idx),
                      (i < ea.size()) ? ea[i] : 32'h0);
            if (gap > 0 && i < len) begin
                repeat (gap) @(posedge clk);
                #1;
            end
        end
        chk("wready_drop", {63'd0, wready}, 64'd0);
        chk("bvalid_rise", {63'd0, bvalid}, 64'd1);
        repeat (bdelay) @(posedge clk);
        #1;
        bready = 1'b1;
        n = 0;
        while (!bvalid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!bvalid) chk("bvalid_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        bready = 1'b0;
        chk("busy_after_b", {63'd0, ctrl_busy}, 64'd0);
        chk("bvalid_after_b", {63'd0, bvalid}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        aw_start = 1'b0; aw_addr = '0; aw_id = '0; aw_len = '0; aw_size = '0; aw_burst = '0;
        wvalid = 1'b0; wdata = '0; wstrb = '0; wlast = 1'b0; bready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wready", {63'd0, wready}, 64'd0);
        chk("rst_mem_we", {63'd0, mem_we}, 64'd0);
        chk("rst_bvalid", {63'd0, bvalid}, 64'd0);
        chk("rst_busy", {63'd0, ctrl_busy}, 64'd0);
        chk("rst_bid", {60'd0, bid}, 64'd0);
        chk("rst_bresp", {62'd0, bresp}, 64'd0);
        chk("rst_mem_addr", {32'd0, mem_addr}, 64'd0);
        rst = 1'b0;

        ea = {32'h100, 32'h104, 32'h108, 32'h10C};
        run_burst(32'h100, 4'h5, 3, 3'd2, 2'b01, 3, 1'b0, 0, 0, 2'b00);

        ea = {32'h1C, 32'h10, 32'h14, 32'h18};
        run_burst(32'h1C, 4'h6, 3, 3'd2, 2'b10, 3, 1'b0, 0, 0, 2'b00);

        ea = {32'h40, 32'h40, 32'h40};
        run_burst(32'h40, 4'h7, 2, 3'd2, 2'b00, 2, 1'b0, 2, 0, 2'b00);

        ea = {};
        run_burst(32'h80, 4'h8, 1, 3'd2, 2'b11, 1, 1'b1, 0, 0, 2'b10);
        run_burst(32'h00, 4'h9, 2, 3'd2, 2'b10, 2, 1'b1, 0, 0, 2'b10);
        run_burst(32'h00, 4'hA, 1, 3'd3, 2'b01, 1, 1'b1, 0, 0, 2'b10);

        ea = {32'h300, 32'h304};
        run_burst(32'h300, 4'hB, 3, 3'd2, 2'b01, 1, 1'b0, 0, 5, 2'b10);

        ea = {32'h101, 32'h104, 32'h108};
        run_burst(32'h101, 4'hC, 2, 3'd2, 2'b01, 2, 1'b0, 1, 0, 2'b00);

        // Reset during beat 2 of an INCR len=7 burst: no B may follow
        start_aw(32'h200, 4'h3, 7, 3'd2, 2'b01);
        send_beat(32'hA000_0000, 4'hF, 1'b0, 1'b1, 32'h200);
        send_beat(32'hA000_0001, 4'hF, 1'b0, 1'b1, 32'h204);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst_busy", {63'd0, ctrl_busy}, 64'd0);
        chk("midrst_wready", {63'd0, wready}, 64'd0);
        chk("midrst_bvalid", {63'd0, bvalid}, 64'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("midrst_no_b", {63'd0, bvalid}, 64'd0);

        ea = {32'h500};
        run_burst(32'h500, 4'hD, 0, 3'd2, 2'b01, 0, 1'b0, 0, 0, 2'b00);

        repeat (3) @(posedge clk);
        #1;
        chk("wr_queue_empty", 64'(wr_q.size()), 64'd0);
        chk("b_queue_empty", 64'(b_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
